// File: rtl/subpel_interp_engine_if.sv
// Handshake bundle for the subpel interpolation engine: block config,
// reference-row input stream and prediction-row output stream.
interface subpel_interp_engine_if #(
  parameter int PIXEL_W   = 8,
  parameter int NUM_PIXEL = 8
);
  logic                              cfg_valid;
  logic                              cfg_ready;
  logic [1:0]                        frac_x;
  logic [1:0]                        frac_y;
  logic                              in_valid;
  logic                              in_ready;
  logic [(NUM_PIXEL+7)*PIXEL_W-1:0]  in_row;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_PIXEL*PIXEL_W-1:0]      out_row;
  logic                              out_last;
  logic                              busy;

  modport master (
    output cfg_valid, frac_x, frac_y, in_valid, in_row, out_ready,
    input  cfg_ready, in_ready, out_valid, out_row, out_last, busy
  );

  modport slave (
    input  cfg_valid, frac_x, frac_y, in_valid, in_row, out_ready,
    output cfg_ready, in_ready, out_valid, out_row, out_last, busy
  );
endinterface

// File: rtl/subpel_interp_engine.sv
// Separable HEVC 8-tap quarter-pel luma interpolator: horizontal pass per
// accepted row, vertical pass over an 8-row window, valid/ready flow control.
module subpel_interp_engine #(
  parameter int PIXEL_W   = 8,
  parameter int NUM_PIXEL = 8,
  parameter int BLK_H     = 8,
  parameter int IW        = PIXEL_W + 8
) (
  input logic clk,
  input logic rst,
  subpel_interp_engine_if.slave bus
);
  localparam int IN_W = (NUM_PIXEL + 7) * PIXEL_W;
  localparam int OUT_W = NUM_PIXEL * PIXEL_W;
  localparam int AW = IW + 8;
  localparam int CW = $clog2(BLK_H + 7);
  localparam logic [CW-1:0] LAST_IN = CW'(BLK_H + 6);
  localparam logic [CW-1:0] FIRST_OUT = CW'(7);
  localparam logic signed [AW-1:0] PMAX = AW'((1 << PIXEL_W) - 1);

  localparam logic signed [7:0] CA [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam logic signed [7:0] CB [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam logic signed [7:0] CC [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_fx;
  logic [1:0]            r_fy;
  logic signed [IW-1:0]  r_win [8][NUM_PIXEL];
  logic [OUT_W-1:0]      r_row_p1;
  logic                  r_vld_p1;
  logic                  r_last_p1;

  logic                  w_cfg_acc;
  logic                  w_in_acc;
  logic                  w_load;
  logic signed [IW-1:0]  w_h [NUM_PIXEL];
  logic signed [IW-1:0]  w_vtap [NUM_PIXEL][8];
  logic [OUT_W-1:0]      w_out_row;

  function automatic logic signed [7:0] coef(input logic [1:0] frac, input logic [2:0] tap);
    case (frac)
      2'd1:    return CA[tap];
      2'd2:    return CB[tap];
      2'd3:    return CC[tap];
      default: return 8'sd0;
    endcase
  endfunction

  function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] v, input int sh);
    logic signed [AW-1:0] half;
    half = AW'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic [PIXEL_W-1:0] clip(input logic signed [AW-1:0] v);
    if (v < 0) return '0;
    if (v > PMAX) return '1;
    return v[PIXEL_W-1:0];
  endfunction

  // Integer position passes pixel i+3 through unfiltered and unscaled.
  function automatic logic signed [IW-1:0] hfilt(input logic [IN_W-1:0] row, input int lane,
                                                 input logic [1:0] fx);
    logic signed [IW-1:0] acc;
    logic signed [IW-1:0] px;
    acc = '0;
    for (int t = 0; t < 8; t++) begin
      px = signed'(IW'(row[(lane + t) * PIXEL_W +: PIXEL_W]));
      if (fx == 2'd0 && t == 3) return px;
      acc = acc + IW'(coef(fx, 3'(t))) * px;
    end
    return acc;
  endfunction

  function automatic logic [PIXEL_W-1:0] vfilt(input logic signed [IW-1:0] r [8],
                                              input logic [1:0] fx, input logic [1:0] fy);
    logic signed [AW-1:0] acc;
    acc = '0;
    for (int t = 0; t < 8; t++)
      acc = acc + AW'(coef(fy, 3'(t))) * AW'(r[t]);
    if (fy == 2'd0) begin
      if (fx == 2'd0) return clip(AW'(r[3]));
      return clip(round_shift(AW'(r[3]), 6));
    end
    if (fx == 2'd0) return clip(round_shift(acc, 6));
    return clip(round_shift(acc, 12));
  endfunction

  assign bus.cfg_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.in_ready  = (r_state == S_RUN) && (!r_vld_p1 || bus.out_ready);
  assign bus.out_valid = r_vld_p1;
  assign bus.out_row   = r_row_p1;
  assign bus.out_last  = r_last_p1;

  assign w_cfg_acc = bus.cfg_valid && (r_state == S_IDLE);
  assign w_in_acc  = bus.in_valid && bus.in_ready;
  assign w_load    = w_in_acc && (r_cnt >= FIRST_OUT);

  always_comb begin
    for (int i = 0; i < NUM_PIXEL; i++)
      w_h[i] = hfilt(bus.in_row, i, r_fx);
  end

  always_comb begin
    for (int i = 0; i < NUM_PIXEL; i++) begin
      for (int j = 0; j < 7; j++)
        w_vtap[i][j] = r_win[j+1][i];
      w_vtap[i][7] = w_h[i];
    end
  end

  always_comb begin
    w_out_row = '0;
    for (int i = 0; i < NUM_PIXEL; i++)
      w_out_row[i*PIXEL_W +: PIXEL_W] = vfilt(w_vtap[i], r_fx, r_fy);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.cfg_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_in_acc && r_cnt == LAST_IN) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_vld_p1 && bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      for (int j = 0; j < 8; j++)
        for (int i = 0; i < NUM_PIXEL; i++)
          r_win[j][i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_acc) begin
        r_fx  <= bus.frac_x;
        r_fy  <= bus.frac_y;
        r_cnt <= '0;
      end else if (w_in_acc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_in_acc) begin
        for (int j = 0; j < 7; j++)
          r_win[j] <= r_win[j+1];
        r_win[7] <= w_h;
      end
    end
  end

  // Output stage: one row register, held until the downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_row_p1  <= '0;
    end else if (w_load) begin
      r_vld_p1  <= 1'b1;
      r_last_p1 <= (r_cnt == LAST_IN);
      r_row_p1  <= w_out_row;
    end else if (r_vld_p1 && bus.out_ready) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_subpel_interp_engine.sv
// Directed bench for subpel_interp_engine: hand-computed rows for each frac
// mode, saturation, backpressure, mid-block reset and ignored reconfiguration.
module tb_subpel_interp_engine;
  localparam int PIXEL_W   = 8;
  localparam int NUM_PIXEL = 8;
  localparam int BLK_H     = 8;
  localparam int IN_W  = (NUM_PIXEL + 7) * PIXEL_W;
  localparam int OUT_W = NUM_PIXEL * PIXEL_W;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  subpel_interp_engine_if #(.PIXEL_W(PIXEL_W), .NUM_PIXEL(NUM_PIXEL)) bus ();

  subpel_interp_engine #(
    .PIXEL_W(PIXEL_W), .NUM_PIXEL(NUM_PIXEL), .BLK_H(BLK_H), .IW(PIXEL_W + 8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_W-1:0] cap [256];
  logic             cap_last [256];
  int               cap_total = 0;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready && cap_total < 256) begin
      cap[cap_total]      <= bus.out_row;
      cap_last[cap_total] <= bus.out_last;
      cap_total           <= cap_total + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] build_row(input int mode, input int r);
    logic [IN_W-1:0] v;
    int p;
    v = '0;
    for (int j = 0; j < NUM_PIXEL + 7; j++) begin
      case (mode)
        0:       p = 16 * r + j;
        1:       p = 100;
        2:       p = (j == 3 || j == 4) ? 255 : 0;
        3:       p = (j == 2 || j == 5) ? 255 : 0;
        4:       p = (j == 3) ? 64 : 0;
        5:       p = (r == 3) ? 64 : 0;
        default: p = 16 * r + j + 1;
      endcase
      v[j*PIXEL_W +: PIXEL_W] = p[PIXEL_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] ramp_exp(input int k, input int off);
    logic [OUT_W-1:0] v;
    int p;
    v = '0;
    for (int i = 0; i < NUM_PIXEL; i++) begin
      p = 16 * (k + 3) + i + 3 + off;
      v[i*PIXEL_W +: PIXEL_W] = p[PIXEL_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] fill(input int p);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PIXEL; i++) v[i*PIXEL_W +: PIXEL_W] = p[PIXEL_W-1:0];
    return v;
  endfunction

  task automatic send_row(input logic [IN_W-1:0] row);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    @(negedge clk);
    while (!bus.in_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check_int("in_ready_timeout", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rows(input int mode, input int first, input int last);
    for (int r = first; r <= last; r++) send_row(build_row(mode, r));
  endtask

  task automatic start_cfg(input logic [1:0] fx, input logic [1:0] fy);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.cfg_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cfg_ready) check_int("cfg_ready_timeout", int'(bus.cfg_ready), 1);
    bus.cfg_valid = 1'b1;
    bus.frac_x    = fx;
    bus.frac_y    = fy;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) check_int("busy_timeout", int'(bus.busy), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.frac_x    = 2'd0;
    bus.frac_y    = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_int("rst_cfg_ready", int'(bus.cfg_ready), 1);
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_int("rst_in_ready", int'(bus.in_ready), 0);
    check_int("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_row", bus.out_row, '0);

    // Integer position: ramp passes straight through, out_last on row 7 only
    base = cap_total;
    start_cfg(2'd0, 2'd0);
    send_rows(0, 0, BLK_H + 6);
    wait_idle();
    check_int("int_count", cap_total - base, BLK_H);
    for (int k = 0; k < BLK_H; k++) begin
      check($sformatf("int_row%0d", k), cap[base+k], ramp_exp(k, 0));
      check_int($sformatf("int_last%0d", k), int'(cap_last[base+k]), (k == BLK_H - 1) ? 1 : 0);
    end
    check_int("int_busy_end", int'(bus.busy), 0);

    // Flat field through both 2-D paths
    base = cap_total;
    start_cfg(2'd2, 2'd2);
    send_rows(1, 0, BLK_H + 6);
    wait_idle();
    check_int("hh_count", cap_total - base, BLK_H);
    for (int k = 0; k < BLK_H; k++) check($sformatf("hh_row%0d", k), cap[base+k], fill(100));

    base = cap_total;
    start_cfg(2'd1, 2'd3);
    send_rows(1, 0, BLK_H + 6);
    wait_idle();
    for (int k = 0; k < BLK_H; k++) check($sformatf("qt_row%0d", k), cap[base+k], fill(100));

    // Half-pel horizontal saturation, both ends
    base = cap_total;
    start_cfg(2'd2, 2'd0);
    send_rows(2, 0, BLK_H + 6);
    wait_idle();
    for (int k = 0; k < BLK_H; k++)
      check_int($sformatf("sat_hi_row%0d", k), int'(cap[base+k][7:0]), 255);

    base = cap_total;
    start_cfg(2'd2, 2'd0);
    send_rows(3, 0, BLK_H + 6);
    wait_idle();
    for (int k = 0; k < BLK_H; k++)
      check_int($sformatf("sat_lo_row%0d", k), int'(cap[base+k][7:0]), 0);

    // Quarter-pel horizontal impulse: lanes 58, 0(-10 clipped), 4, 0(floor -1)
    base = cap_total;
    start_cfg(2'd1, 2'd0);
    send_rows(4, 0, BLK_H + 6);
    wait_idle();
    for (int k = 0; k < BLK_H; k++)
      check($sformatf("hq_row%0d", k), cap[base+k], 64'h0000_0000_0004_003A);

    // Quarter-pel vertical impulse on input row 3
    base = cap_total;
    start_cfg(2'd0, 2'd1);
    send_rows(5, 0, BLK_H + 6);
    wait_idle();
    for (int k = 0; k < BLK_H; k++)
      check($sformatf("vq_row%0d", k), cap[base+k], fill((k == 0) ? 58 : (k == 2) ? 4 : 0));

    // Downstream stall for 5 cycles with the first output pending
    base = cap_total;
    start_cfg(2'd0, 2'd0);
    send_rows(0, 0, 7);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_row    = build_row(0, 8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_int($sformatf("stall_in_ready%0d", c), int'(bus.in_ready), 0);
      check_int($sformatf("stall_out_valid%0d", c), int'(bus.out_valid), 1);
      check($sformatf("stall_out_row%0d", c), bus.out_row, ramp_exp(0, 0));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send_rows(0, 8, BLK_H + 6);
    wait_idle();
    check_int("stall_count", cap_total - base, BLK_H);
    for (int k = 0; k < BLK_H; k++) check($sformatf("stall_row%0d", k), cap[base+k], ramp_exp(k, 0));

    // Reset after 9 accepted rows, then a clean block
    start_cfg(2'd0, 2'd0);
    send_rows(0, 0, 8);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    check_int("mrst_cfg_ready", int'(bus.cfg_ready), 1);
    check_int("mrst_out_valid", int'(bus.out_valid), 0);
    check_int("mrst_busy", int'(bus.busy), 0);
    check("mrst_out_row", bus.out_row, '0);
    base = cap_total;
    start_cfg(2'd0, 2'd0);
    send_rows(6, 0, BLK_H + 6);
    wait_idle();
    check_int("mrst_count", cap_total - base, BLK_H);
    for (int k = 0; k < BLK_H; k++) check($sformatf("mrst_row%0d", k), cap[base+k], ramp_exp(k, 1));

    // Reconfiguration attempt in RUN must not alter the block
    base = cap_total;
    start_cfg(2'd0, 2'd0);
    send_rows(0, 0, 3);
    bus.cfg_valid = 1'b1;
    bus.frac_x    = 2'd2;
    bus.frac_y    = 2'd2;
    check_int("ign_cfg_ready", int'(bus.cfg_ready), 0);
    send_row(build_row(0, 4));
    bus.cfg_valid = 1'b0;
    send_rows(0, 5, BLK_H + 6);
    wait_idle();
    check_int("ign_count", cap_total - base, BLK_H);
    for (int k = 0; k < BLK_H; k++) check($sformatf("ign_row%0d", k), cap[base+k], ramp_exp(k, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/subpel_interp_engine.md
Name: subpel_interp_engine

Overview:
- Parametrised, handshaked successor of the fixed 8-lane luma subpixel interpolator.
- Applies the HEVC 8-tap quarter-pel luma filters as a separable pair: horizontal pass per input row, then vertical pass over an 8-row window.
- Processes one NUM_PIXEL x BLK_H block per configuration, with a runtime-selected fractional position (frac_x, frac_y).
- Sits between the reference-row fetch buffer and the prediction output buffer; replaces the free-running counter/mux sequencing with valid/ready flow control.

Parameters:
PIXEL_W, 8, bits per pixel
NUM_PIXEL, 8, output lanes (pixels per output row)
BLK_H, 8, output rows per block
IW, PIXEL_W+8, signed width of horizontal intermediates

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  block start request
cfg_ready  out  1  high only in IDLE
frac_x  in  2  0 = integer, 1 = quarter (A), 2 = half (B), 3 = three-quarter (C)
frac_y  in  2  same encoding, vertical
in_valid  in  1  input row valid
in_ready  out  1  input row accepted when in_valid && in_ready
in_row  in  (NUM_PIXEL+7)*PIXEL_W  pixel j at [j*PIXEL_W +: PIXEL_W]
out_valid  out  1  output row valid
out_ready  in  1  downstream accept
out_row  out  NUM_PIXEL*PIXEL_W  lane i at [i*PIXEL_W +: PIXEL_W]
out_last  out  1  marks row BLK_H-1 of the block
busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous active-high. State = IDLE; row counter, window and out_row are all 0. out_valid=0, out_last=0, busy=0, in_ready=0, cfg_ready=1.
- Reset mid-block discards the partial block; no output is emitted for it.
- Coefficients, taps 0..7:
  - A: -1, 4, -10, 58, 17, -5, 1, 0
  - B: -1, 4, -11, 40, 40, -11, 4, -1
  - C: 0, 1, -5, 17, 58, -10, 4, -1
- FSM IDLE -> RUN on cfg_valid && cfg_ready; frac_x and frac_y are latched on that edge and the row counter is cleared.
- FSM RUN -> DRAIN on acceptance of row BLK_H+6.
- FSM DRAIN -> IDLE on out_valid && out_ready.
- cfg_valid outside IDLE is ignored.
- Every block consumes exactly BLK_H+7 input rows, whatever the frac values.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Horizontal pass, lane i, uses pixels i..i+7 of the accepted row:
  - frac_x = 0: H = pixel[i+3] (zero-extended to IW).
  - frac_x != 0: H = signed tap sum, unrounded, IW bits.
- Window: an 8-entry shift register of H rows. On each accepted row it shifts and the new H row enters as entry 7.
- Output row k is produced on acceptance of input row k+7. out_row is loaded on that same edge from the combinational vertical pass over {window entries 1..7, new H row}. Latency is 1 cycle: out_valid rises the cycle after that acceptance.
- Vertical pass, lane i, over rows r0..r7:
  - fx=0, fy=0: out = r3.
  - fx!=0, fy=0: out = clip((r3 + 32) >>> 6).
  - fx=0, fy!=0: out = clip((sum c_j*r_j + 32) >>> 6).
  - fx!=0, fy!=0: out = clip((sum c_j*r_j + 2048) >>> 12), with accumulator at least IW+8 bits signed.
  - clip saturates to 0 .. 2^PIXEL_W-1. >>> is arithmetic (floor).
- Output register holds:
  - out_valid stays high until out_ready.
  - out_row and out_last stay stable while out_valid && !out_ready.
  - out_valid clears on the handshake unless a new row loads on the same edge; in that case it stays high with the new data.
- out_last = 1 with output row BLK_H-1 only.
- Input stall (in_valid=0) does not change any state.

Test Plan:
- Defaults, fx=0, fy=0, input row r pixel j = 16*r + j -> output row k lane i = 16*(k+3) + i+3; 8 rows; out_last on row 7 only; busy returns to 0 after the last handshake.
- All pixels 100, fx=2, fy=2 -> every output = 100. All pixels 100, fx=1, fy=3 -> every output = 100.
- fx=2, fy=0, every row with pixels 3 and 4 = 255 and others 0 -> lane 0 output = 255 (sum 20400, clipped). With pixels 2 and 5 = 255 instead -> lane 0 output = 0 (sum -5610, clipped).
- out_ready held low 5 cycles with out_valid high -> in_ready=0, out_row unchanged, no row lost; all 8 outputs still match the model.
- Assert rst while 9 rows are accepted -> next cycle cfg_ready=1, out_valid=0. A new block then produces correct data with no residue from the old window.
- cfg_valid pulsed during RUN with different frac values -> ignored; the block completes with the original frac values.
